// File: rtl/slave_mem.sv
// rtl/slave_mem.sv - memory-backed slave on split addr/cmd/write-data channels with a valid/ready read response
// Optional build macro SLAVE_MEM_CLEAR_EN: asynchronous reset also zeroes the memory array.
module slave_mem #(
    parameter int W      = 8,
    parameter int A      = 4,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [A-1:0] addr,
    input  logic         addr_val,
    output logic         addr_rdy,
    input  logic         cmd,
    input  logic         cmd_val,
    output logic         cmd_rdy,
    input  logic [W-1:0] wr_data,
    input  logic         wr_val,
    output logic         wr_rdy,
    output logic [W-1:0] rd_data,
    output logic         rd_val,
    input  logic         rd_rdy
);
    localparam int DEPTH = 1 << A;

    typedef enum logic [1:0] {S_COLLECT, S_EXEC, S_WAIT, S_RESP} state_t;

    state_t       state, state_nxt;
    logic         addr_got, cmd_got, wr_got;
    logic [A-1:0] addr_q;
    logic         cmd_q;
    logic [W-1:0] wr_q;
    logic [W-1:0] rd_word;
    logic [1:0]   cnt;
    logic [W-1:0] mem [DEPTH];

    logic addr_hs, cmd_hs, wr_hs;
    logic cmd_eff, go;

    assign addr_hs = addr_val & addr_rdy;
    assign cmd_hs  = cmd_val & cmd_rdy;
    assign wr_hs   = wr_val & wr_rdy;

    // Look through this cycle's handshakes so EXEC follows the last capture directly.
    assign cmd_eff = cmd_got ? cmd_q : cmd;
    assign go      = (addr_got | addr_hs) & (cmd_got | cmd_hs) & (!cmd_eff | wr_got | wr_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_COLLECT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_COLLECT: if (go) state_nxt = S_EXEC;
            S_EXEC:    state_nxt = cmd_q ? S_COLLECT : S_WAIT;
            S_WAIT:    if (cnt == 2'd0) state_nxt = S_RESP;
            S_RESP:    if (rd_rdy) state_nxt = S_COLLECT;
            default:   state_nxt = S_COLLECT;
        endcase
    end

    // Readies come only from registered state so they never loop back through the *_val inputs.
    always_comb begin
        addr_rdy = 1'b0;
        cmd_rdy  = 1'b0;
        wr_rdy   = 1'b0;
        if (state == S_COLLECT) begin
            addr_rdy = !addr_got;
            cmd_rdy  = !cmd_got;
            wr_rdy   = !wr_got & cmd_got & cmd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_got <= 1'b0;
            cmd_got  <= 1'b0;
            wr_got   <= 1'b0;
            addr_q   <= '0;
            cmd_q    <= 1'b0;
            wr_q     <= '0;
            rd_word  <= '0;
            cnt      <= 2'd0;
            rd_data  <= '0;
            rd_val   <= 1'b0;
        end else begin
            case (state)
                S_COLLECT: begin
                    if (addr_hs) begin
                        addr_q   <= addr;
                        addr_got <= 1'b1;
                    end
                    if (cmd_hs) begin
                        cmd_q   <= cmd;
                        cmd_got <= 1'b1;
                    end
                    if (wr_hs) begin
                        wr_q   <= wr_data;
                        wr_got <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cmd_q) begin
                        addr_got <= 1'b0;
                        cmd_got  <= 1'b0;
                        wr_got   <= 1'b0;
                    end else begin
                        rd_word <= mem[addr_q];
                        cnt     <= 2'(RD_LAT - 1);
                    end
                end
                S_WAIT: begin
                    if (cnt == 2'd0) begin
                        rd_data <= rd_word;
                        rd_val  <= 1'b1;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (rd_rdy) begin
                        rd_val   <= 1'b0;
                        addr_got <= 1'b0;
                        cmd_got  <= 1'b0;
                        wr_got   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SLAVE_MEM_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == S_EXEC && cmd_q) begin
            mem[addr_q] <= wr_q;
        end
    end
`else
    // An asynchronous reset forces COLLECT, so a write caught in EXEC is dropped.
    always_ff @(posedge clk) begin
        if (state == S_EXEC && cmd_q) mem[addr_q] <= wr_q;
    end
`endif

endmodule

// File: tb/tb_slave_mem.sv
// tb/tb_slave_mem.sv - directed bench for slave_mem, RD_LAT=1 and RD_LAT=4 instances
module tb_slave_mem;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] addr = '0;
    logic       addr_val = 1'b0, cmd = 1'b0, cmd_val = 1'b0, wr_val = 1'b0, rd_rdy = 1'b0;
    logic [7:0] wr_data = '0;

    logic       ar1, cr1, wr1, rv1, ar4, cr4, wr4, rv4;
    logic [7:0] rd1, rd4;
    logic       addr_rdy, cmd_rdy, wr_rdy, rd_val;
    logic [7:0] rd_data;

    int  tests = 0;
    int  fails = 0;
    bit  wr_seen;
    logic [7:0] exp5;

    always #5 clk = ~clk;

    slave_mem #(.W(8), .A(4), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .addr(addr), .addr_val(addr_val & !sel), .addr_rdy(ar1),
        .cmd(cmd), .cmd_val(cmd_val & !sel), .cmd_rdy(cr1),
        .wr_data(wr_data), .wr_val(wr_val & !sel), .wr_rdy(wr1),
        .rd_data(rd1), .rd_val(rv1), .rd_rdy(rd_rdy & !sel)
    );

    slave_mem #(.W(8), .A(4), .RD_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .addr(addr), .addr_val(addr_val & sel), .addr_rdy(ar4),
        .cmd(cmd), .cmd_val(cmd_val & sel), .cmd_rdy(cr4),
        .wr_data(wr_data), .wr_val(wr_val & sel), .wr_rdy(wr4),
        .rd_data(rd4), .rd_val(rv4), .rd_rdy(rd_rdy & sel)
    );

    assign addr_rdy = sel ? ar4 : ar1;
    assign cmd_rdy  = sel ? cr4 : cr1;
    assign wr_rdy   = sel ? wr4 : wr1;
    assign rd_val   = sel ? rv4 : rv1;
    assign rd_data  = sel ? rd4 : rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] a, input logic c, input logic [7:0] d, input logic wv);
        logic ha, hc, hw;
        addr = a; addr_val = 1'b1; cmd = c; cmd_val = 1'b1; wr_data = d; wr_val = wv;
        wr_seen = 1'b0;
        for (int i = 0; i < 20 && (addr_val || cmd_val || (c && wr_val)); i++) begin
            ha = addr_val & addr_rdy;
            hc = cmd_val & cmd_rdy;
            hw = wr_val & wr_rdy;
            if (wr_rdy) wr_seen = 1'b1;
            tick();
            if (ha) addr_val = 1'b0;
            if (hc) cmd_val = 1'b0;
            if (hw) wr_val = 1'b0;
        end
        chk("issue_done", {29'd0, addr_val, cmd_val, c & wr_val}, 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        issue(a, 1'b1, d, 1'b1);
    endtask

    task automatic rd_req(input logic [3:0] a, input logic [7:0] exp, input int lat, input logic wv);
        int n;
        issue(a, 1'b0, 8'h99, wv);
        n = 0;
        while (!rd_val && n < 20) begin
            if (wr_rdy) wr_seen = 1'b1;
            tick();
            n++;
        end
        chk("rd_latency", n, lat);
        chk("rd_data", {24'd0, rd_data}, {24'd0, exp});
        chk("rd_no_wr_rdy", {31'd0, wr_seen}, 32'd0);
    endtask

    task automatic rd_done(input logic [7:0] exp, input int hold);
        rd_rdy = 1'b0;
        for (int k = 0; k < hold; k++) begin
            chk("hold_val", {31'd0, rd_val}, 32'd1);
            chk("hold_data", {24'd0, rd_data}, {24'd0, exp});
            tick();
        end
        rd_rdy = 1'b1;
        tick();
        rd_rdy = 1'b0;
        chk("rd_val_drop", {31'd0, rd_val}, 32'd0);
        chk("rd_data_kept", {24'd0, rd_data}, {24'd0, exp});
        chk("ready_after_resp", {30'd0, addr_rdy, cmd_rdy}, 32'd3);
    endtask

    initial begin
`ifdef SLAVE_MEM_CLEAR_EN
        exp5 = 8'h00;
`else
        exp5 = 8'h21;
`endif
        #12;
        chk("rst_addr_rdy", {31'd0, addr_rdy}, 32'd1);
        chk("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
        chk("rst_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        chk("rst_rd_val", {31'd0, rd_val}, 32'd0);
        chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        do_write(4'd3, 8'h5A);
        rd_req(4'd3, 8'h5A, 2, 1'b0);
        rd_done(8'h5A, 0);

        do_write(4'd7, 8'h3C);
        rd_req(4'd7, 8'h3C, 2, 1'b0);
        rd_done(8'h3C, 5);

        addr = 4'd15; addr_val = 1'b1; cmd = 1'b1; cmd_val = 1'b1;
        tick();
        addr_val = 1'b0; cmd_val = 1'b0;
        chk("w15_wr_rdy", {31'd0, wr_rdy}, 32'd1);
        chk("w15_busy_rdys", {30'd0, addr_rdy, cmd_rdy}, 32'd0);
        tick();
        tick();
        chk("w15_wr_rdy_late", {31'd0, wr_rdy}, 32'd1);
        chk("w15_busy_rdys_late", {30'd0, addr_rdy, cmd_rdy}, 32'd0);
        wr_data = 8'hC3; wr_val = 1'b1;
        tick();
        wr_val = 1'b0;
        rd_req(4'd15, 8'hC3, 2, 1'b0);
        rd_done(8'hC3, 0);

        rd_req(4'd3, 8'h5A, 2, 1'b1);
        wr_val = 1'b0;
        rd_done(8'h5A, 0);
        do_write(4'd3, 8'h77);
        rd_req(4'd3, 8'h77, 2, 1'b0);
        rd_done(8'h77, 0);

        do_write(4'd2, 8'h21);
        issue(4'd2, 1'b1, 8'hFF, 1'b1);
        rst_n = 1'b0;
        #2;
        chk("rst_exec_addr_rdy", {31'd0, addr_rdy}, 32'd1);
        chk("rst_exec_wr_rdy", {31'd0, wr_rdy}, 32'd0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        rd_req(4'd2, exp5, 2, 1'b0);
        rd_done(exp5, 0);

        do_write(4'd7, 8'h3C);
        rd_req(4'd7, 8'h3C, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd_val", {31'd0, rd_val}, 32'd0);
        chk("async_rd_data", {24'd0, rd_data}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        sel = 1'b1;
        do_write(4'd0, 8'h11);
        do_write(4'd1, 8'h22);
        rd_req(4'd0, 8'h11, 5, 1'b0);
        rd_done(8'h11, 0);
        rd_req(4'd1, 8'h22, 5, 1'b0);
        rd_done(8'h22, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
